// File: rtl/motor_seq_ctrl.sv
// Motor run sequencer: IDLE -> SPIN_UP -> BOOST -> RUN -> BRAKE with IR revolution count and RUN watchdog.
// Outputs registered with the state (one edge after inputs, IR_catch to rev_cnt four edges); no backpressure.
module motor_seq_ctrl #(
   parameter logic [31:0] SPINUP_CYC = 32'd50_000_000,
   parameter logic [31:0] BOOST_CYC  = 32'd25_000_000,
   parameter logic [31:0] BRAKE_CYC  = 32'd50_000_000,
   parameter logic [31:0] IR_TIMEOUT = 32'd100_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        clear_fault,
   input  logic        IR_catch,
   output logic [3:0]  MOTOR_SSEL,
   output logic        busy,
   output logic        fault,
   output logic [15:0] rev_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SPIN_UP = 3'd1,
      ST_BOOST   = 3'd2,
      ST_RUN     = 3'd3,
      ST_BRAKE   = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  ssel_nxt;
   logic        busy_nxt;
   logic        fault_nxt;

   logic [31:0] dwell_cnt;
   logic [31:0] dwell_lim;
   logic        dwell_done;
   logic        timed_state;

   logic [31:0] wd_cnt;
   logic        wd_expire;

   logic        ir_meta;
   logic        ir_sync;
   logic        ir_sync_q;
   logic        ir_pulse;
   logic        counting;

   // IR_catch is asynchronous: two flops for metastability, a third for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_meta   <= 1'b0;
         ir_sync   <= 1'b0;
         ir_sync_q <= 1'b0;
         ir_pulse  <= 1'b0;
      end else begin
         ir_meta   <= IR_catch;
         ir_sync   <= ir_meta;
         ir_sync_q <= ir_sync;
         ir_pulse  <= ir_sync & ~ir_sync_q;
      end
   end

   always_comb begin
      dwell_lim = BRAKE_CYC;
      case (state)
         ST_SPIN_UP: dwell_lim = SPINUP_CYC;
         ST_BOOST:   dwell_lim = BOOST_CYC;
         default:    dwell_lim = BRAKE_CYC;
      endcase
   end

   assign timed_state = (state == ST_SPIN_UP) || (state == ST_BOOST) || (state == ST_BRAKE);
   assign dwell_done  = (dwell_cnt == dwell_lim - 32'd1);
   // A pulse in the last watchdog cycle still counts as a revolution in time
   assign wd_expire   = (state == ST_RUN) && !ir_pulse && (wd_cnt >= IR_TIMEOUT - 32'd1);
   assign counting    = (state == ST_SPIN_UP) || (state == ST_BOOST) || (state == ST_RUN);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start && !stop)
               state_nxt = ST_SPIN_UP;
         end
         ST_SPIN_UP: begin
            if (stop)
               state_nxt = ST_BRAKE;
            else if (dwell_done)
               state_nxt = ST_BOOST;
         end
         ST_BOOST: begin
            if (stop)
               state_nxt = ST_BRAKE;
            else if (dwell_done)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (wd_expire)
               state_nxt = ST_FAULT;
            else if (stop)
               state_nxt = ST_BRAKE;
         end
         ST_BRAKE: begin
            if (dwell_done)
               state_nxt = ST_IDLE;
         end
         ST_FAULT: begin
            if (clear_fault)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ssel_nxt = 4'd0;
      case (state_nxt)
         ST_SPIN_UP: ssel_nxt = 4'd4;
         ST_BOOST:   ssel_nxt = 4'd5;
         ST_RUN:     ssel_nxt = 4'd6;
         ST_BRAKE:   ssel_nxt = 4'd3;
         default:    ssel_nxt = 4'd0;
      endcase
      busy_nxt  = (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
      fault_nxt = (state_nxt == ST_FAULT);
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         MOTOR_SSEL <= 4'd0;
         busy       <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         MOTOR_SSEL <= ssel_nxt;
         busy       <= busy_nxt;
         fault      <= fault_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dwell_cnt <= 32'd0;
      else if (state_nxt != state || !timed_state)
         dwell_cnt <= 32'd0;
      else
         dwell_cnt <= dwell_cnt + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wd_cnt <= 32'd0;
      else if (state != ST_RUN || state_nxt != ST_RUN || ir_pulse)
         wd_cnt <= 32'd0;
      else
         wd_cnt <= wd_cnt + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rev_cnt <= 16'd0;
      else if (state == ST_IDLE && state_nxt == ST_SPIN_UP)
         rev_cnt <= 16'd0;
      else if (ir_pulse && counting && rev_cnt != 16'hFFFF)
         rev_cnt <= rev_cnt + 16'd1;
   end

endmodule

// File: doc/motor_seq_ctrl.md
MOTOR_SEQ_CTRL -- requirements
Module: motor_seq_ctrl

Interface
REQ-001 Parameter SPINUP_CYC, default 32'd50_000_000, SPIN_UP dwell in clk cycles (min 1).
REQ-002 Parameter BOOST_CYC, default 32'd25_000_000, BOOST dwell in clk cycles (min 1).
REQ-003 Parameter BRAKE_CYC, default 32'd50_000_000, BRAKE dwell in clk cycles (min 1).
REQ-004 Parameter IR_TIMEOUT, default 32'd100_000_000, max clk cycles between IR edges in RUN before fault (min 1).
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  level, sampled each cycle; requests a run sequence.
REQ-008 stop  input  1  level, sampled each cycle; requests controlled stop.
REQ-009 clear_fault  input  1  level; clears sticky fault.
REQ-010 IR_catch  input  1  asynchronous IR pair-tube pulse, one rising edge per revolution.
REQ-011 MOTOR_SSEL  output  4  mode select driving motor_control.
REQ-012 busy  output  1  high in any state other than IDLE and FAULT.
REQ-013 fault  output  1  high in FAULT state.
REQ-014 rev_cnt  output  16  IR rising edges counted in the current run.

Function
REQ-015 States and registered MOTOR_SSEL: IDLE=4'd0, SPIN_UP=4'd4, BOOST=4'd5, RUN=4'd6, BRAKE=4'd3, FAULT=4'd0; MOTOR_SSEL, busy and fault change on the same edge as the state register.
REQ-016 IDLE -> SPIN_UP when start=1 and stop=0; start with stop=1 ignored; rev_cnt cleared to 0 on that edge.
REQ-017 A 32-bit dwell counter shall clear on every state entry and increment each cycle; SPIN_UP, BOOST, BRAKE each last exactly SPINUP_CYC, BOOST_CYC, BRAKE_CYC cycles.
REQ-018 SPIN_UP -> BOOST, BOOST -> RUN, BRAKE -> IDLE on dwell expiry.
REQ-019 stop=1 in SPIN_UP, BOOST or RUN shall move to BRAKE on the next edge, overriding dwell expiry in the same cycle.
REQ-020 RUN persists until stop or watchdog timeout; start while busy is ignored.
REQ-021 IR_catch passes a 2-flop synchronizer then rising-edge detect; ir_pulse asserts 3 clk edges after an IR_catch rise held >= 2 cycles, for one cycle.
REQ-022 rev_cnt increments on ir_pulse in SPIN_UP, BOOST and RUN only; saturates at 16'hFFFF; holds in BRAKE, IDLE, FAULT.
REQ-023 Watchdog counter active only in RUN: cleared on RUN entry and on each ir_pulse, else increments; reaching IR_TIMEOUT shall move to FAULT next edge.
REQ-024 Watchdog timeout and stop in the same cycle: FAULT wins.
REQ-025 FAULT is sticky: MOTOR_SSEL=0, start ignored; clear_fault=1 -> IDLE next edge.
REQ-026 Unreachable state encodings shall recover to IDLE next edge with MOTOR_SSEL=0.

Reset
REQ-027 rst_n=0 shall immediately force state IDLE, MOTOR_SSEL=4'd0, busy=0, fault=0, rev_cnt=0, all counters and synchronizer flops 0, regardless of clock.
REQ-028 Reset mid-sequence (any state) shall abort without passing through BRAKE; after release, first start begins a fresh SPIN_UP.

Verification (SPINUP_CYC=8, BOOST_CYC=4, BRAKE_CYC=6, IR_TIMEOUT=10)
REQ-029 start pulse 1 cycle at t0, IR edges every 5 cycles -> SSEL 0->4 at t0+1, 4->5 at t0+9, 5->6 at t0+13, stays 6, busy=1 from t0+1.
REQ-030 In RUN assert stop 1 cycle -> SSEL=3 next edge for 6 cycles, then 0, busy=0, rev_cnt holds final count.
REQ-031 Enter RUN, no IR edges -> SSEL=0 and fault=1 exactly 10 cycles after RUN entry; start ignored; clear_fault -> IDLE next edge, fault=0.
REQ-032 stop asserted on the cycle SPIN_UP dwell expires -> BRAKE (SSEL=3), not BOOST.
REQ-033 rst_n low asynchronously in BOOST between clock edges -> SSEL=0, busy=0, rev_cnt=0 before next edge.
REQ-034 Drive 65,540 IR edges during RUN (IR_TIMEOUT raised) -> rev_cnt=16'hFFFF, no wrap.
